// File: rtl/mux_rr_nto1.sv
// N-to-1 multiplexer with a single registered output slot. Selection is fixed
// priority or round-robin; the output word is replaced without a bubble when consumed.
module mux_rr_nto1 #(
   parameter int size     = 32,
   parameter int channels = 4,
   parameter int mode     = 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [channels*size-1:0]                  data_i,
   input  logic [channels-1:0]                       valid_i,
   output logic [channels-1:0]                       ready_o,
   output logic [size-1:0]                           data_o,
   output logic                                      valid_o,
   input  logic                                      ready_i,
   output logic [((channels > 1) ? $clog2(channels) : 1)-1:0] sel_o
);

   localparam int sel_w = (channels > 1) ? $clog2(channels) : 1;

   logic [sel_w-1:0]    ptr_r;
   logic [sel_w-1:0]    sel_r;
   logic [size-1:0]     data_r;
   logic                valid_r;
   logic [sel_w-1:0]    base_s;
   logic [sel_w-1:0]    win_s;
   logic                any_s;
   logic                load_en_s;
   logic                in_xfer_s;
   logic [channels-1:0] grant_s;

   // (base + off) mod channels, valid for off < channels and base < channels
   function automatic logic [sel_w-1:0] rr_idx(input logic [sel_w-1:0] base,
                                                input int unsigned      off);
      logic [sel_w:0] sum;
      sum = {1'b0, base} + (sel_w+1)'(off);
      if (sum >= (sel_w+1)'(channels)) begin
         sum = sum - (sel_w+1)'(channels);
      end else begin
         sum = sum;
      end
      return sum[sel_w-1:0];
   endfunction

   assign base_s    = (mode == 32'sd0) ? {sel_w{1'b0}} : ptr_r;
   assign load_en_s = (!valid_r || ready_i) && !rst_i;
   assign in_xfer_s = load_en_s && any_s;

   // Winner search: walk from the highest search position down so the first hit wins
   always_comb begin
      win_s = {sel_w{1'b0}};
      any_s = 1'b0;
      for (int i = channels - 1; i >= 0; i--) begin
         win_s = valid_i[rr_idx(base_s, i)] ? rr_idx(base_s, i) : win_s;
         any_s = any_s | valid_i[rr_idx(base_s, i)];
      end
   end

   // One-hot grant, only while the output slot can take a word
   always_comb begin
      grant_s = {channels{1'b0}};
      if (in_xfer_s) begin
         grant_s[win_s] = 1'b1;
      end else begin
         grant_s = {channels{1'b0}};
      end
   end

   // Output slot and round-robin pointer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_r <= 1'b0;
         data_r  <= {size{1'b0}};
         sel_r   <= {sel_w{1'b0}};
         ptr_r   <= {sel_w{1'b0}};
      end else if (in_xfer_s) begin
         valid_r <= 1'b1;
         data_r  <= data_i[32'(win_s)*size +: size];
         sel_r   <= win_s;
         ptr_r   <= rr_idx(win_s, 1);
      end else if (ready_i) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign ready_o = grant_s;
   assign data_o  = data_r;
   assign valid_o = valid_r;
   assign sel_o   = sel_r;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1: round-robin instance plus a fixed-priority instance
// sharing the same stimulus.
module tb_mux_rr_nto1;

   logic         clk;
   logic         rst;
   logic [127:0] data_s;
   logic [3:0]   valid_s;
   logic         rdy_in;
   logic [3:0]   rr_ready;
   logic [31:0]  rr_data;
   logic         rr_valid;
   logic [1:0]   rr_sel;
   logic [3:0]   fp_ready;
   logic [31:0]  fp_data;
   logic         fp_valid;
   logic [1:0]   fp_sel;
   int           total = 0;
   int           bad   = 0;

   mux_rr_nto1 #(.size(32), .channels(4), .mode(1)) dut (
      .clk_i(clk), .rst_i(rst), .data_i(data_s), .valid_i(valid_s),
      .ready_o(rr_ready), .data_o(rr_data), .valid_o(rr_valid),
      .ready_i(rdy_in), .sel_o(rr_sel));

   mux_rr_nto1 #(.size(32), .channels(4), .mode(0)) dut_fp (
      .clk_i(clk), .rst_i(rst), .data_i(data_s), .valid_i(valid_s),
      .ready_o(fp_ready), .data_o(fp_data), .valid_o(fp_valid),
      .ready_i(rdy_in), .sel_o(fp_sel));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      valid_s = 4'b0000;
      rdy_in  = 1'b0;
      for (int k = 0; k < 4; k++) data_s[k*32 +: 32] = 32'h10 + k;
      step();
      step();
      check_val("rst_valid", {31'd0, rr_valid}, 32'd0);
      check_val("rst_data", rr_data, 32'd0);
      check_val("rst_sel", {30'd0, rr_sel}, 32'd0);
      valid_s = 4'b1111;
      #1;
      check_val("rst_ready", {28'd0, rr_ready}, 32'd0);

      // round-robin fairness, one word per cycle
      rst    = 1'b0;
      rdy_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_val("rr_ready", {28'd0, rr_ready}, 32'd1 << (i % 4));
         step();
         check_val("rr_sel", {30'd0, rr_sel}, i % 4);
         check_val("rr_data", rr_data, 32'h10 + (i % 4));
         check_val("rr_valid", {31'd0, rr_valid}, 32'd1);
      end

      // idle: slot drains, data holds, pointer stays at 1
      valid_s = 4'b0000;
      #1;
      check_val("idle_ready", {28'd0, rr_ready}, 32'd0);
      step();
      check_val("idle_valid", {31'd0, rr_valid}, 32'd0);
      check_val("idle_data", rr_data, 32'h10);
      valid_s = 4'b1111;
      #1;
      check_val("idle_ptr", {28'd0, rr_ready}, 32'b0010);

      // backpressure: ch2 word stalls, then ch3 replaces it on release
      data_s[2*32 +: 32] = 32'hA5A5A5A5;
      valid_s = 4'b0100;
      rdy_in  = 1'b0;
      #1;
      check_val("bp_load_ready", {28'd0, rr_ready}, 32'b0100);
      step();
      valid_s = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_val("bp_ready", {28'd0, rr_ready}, 32'd0);
         step();
         check_val("bp_data", rr_data, 32'hA5A5A5A5);
         check_val("bp_sel", {30'd0, rr_sel}, 32'd2);
         check_val("bp_valid", {31'd0, rr_valid}, 32'd1);
      end
      rdy_in = 1'b1;
      #1;
      check_val("bp_rel_ready", {28'd0, rr_ready}, 32'b1000);
      step();
      check_val("bp_rel_data", rr_data, 32'h13);
      check_val("bp_rel_sel", {30'd0, rr_sel}, 32'd3);

      // pointer wrap: ch2 transfer leaves ptr at 3
      valid_s = 4'b0100;
      step();
      valid_s = 4'b0011;
      #1;
      check_val("wrap_ready0", {28'd0, rr_ready}, 32'b0001);
      step();
      check_val("wrap_sel0", {30'd0, rr_sel}, 32'd0);
      check_val("wrap_data0", rr_data, 32'h10);
      check_val("wrap_ready1", {28'd0, rr_ready}, 32'b0010);
      step();
      check_val("wrap_sel1", {30'd0, rr_sel}, 32'd1);
      check_val("wrap_data1", rr_data, 32'h11);

      // reset mid-stream
      data_s[0 +: 32] = 32'hDEADBEEF;
      valid_s = 4'b0001;
      step();
      check_val("mid_data", rr_data, 32'hDEADBEEF);
      rst    = 1'b1;
      rdy_in = 1'b0;
      #1;
      check_val("mid_rst_ready", {28'd0, rr_ready}, 32'd0);
      step();
      check_val("mid_valid", {31'd0, rr_valid}, 32'd0);
      check_val("mid_data0", rr_data, 32'd0);
      check_val("mid_sel0", {30'd0, rr_sel}, 32'd0);
      rst     = 1'b0;
      rdy_in  = 1'b1;
      valid_s = 4'b1111;
      #1;
      check_val("mid_ptr0", {28'd0, rr_ready}, 32'b0001);

      // fixed priority on the mode-0 instance
      data_s[0 +: 32] = 32'h10;
      valid_s = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("fp_ready", {28'd0, fp_ready}, 32'b0010);
         step();
         check_val("fp_sel", {30'd0, fp_sel}, 32'd1);
         check_val("fp_data", fp_data, 32'h11);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
